mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, width of address/data fields.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, width of tags; bit 12 = 1 means read, 0 means write.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL provide, for N = 0 (instruction cache) and 1 (data cache):
- sN_reqcyc, input, 1, request valid.
- sN_reqack, output, 1, request or data beat accepted.
- sN_req, input, BUS_DATA_WIDTH, address or write data.
- sN_reqtag, input, BUS_TAG_WIDTH, request tag.
- sN_respcyc, output, 1, response beat valid.
- sN_respack, input, 1, response beat accepted.
- sN_resp, output, BUS_DATA_WIDTH, response data.
- sN_resptag, output, BUS_TAG_WIDTH, response tag.
REQ-006 SHALL provide the memory-side port:
- m_bus_reqcyc, output, 1, request/data beat valid to DRAM.
- m_bus_reqack, input, 1, DRAM accepted beat.
- m_bus_req, output, BUS_DATA_WIDTH, address or write data.
- m_bus_reqtag, output, BUS_TAG_WIDTH, tag.
- m_bus_respcyc, input, 1, DRAM response beat valid.
- m_bus_respack, output, 1, response beat accepted.
- m_bus_resp, input, BUS_DATA_WIDTH, response data.
- m_bus_resptag, input, BUS_TAG_WIDTH, response tag.

Function
REQ-007 SHALL implement states IDLE, HDR, WDATA, RDATA, with a 1-bit registered grant g and a 1-bit last-served pointer lp.
REQ-008 SHALL, in IDLE, register the grant and go to HDR when any sN_reqcyc=1:
- only one requester asserts: grant it.
- both assert: grant the one not equal to lp (round-robin).
- in IDLE all outputs to both requesters and DRAM are 0.
REQ-009 SHALL, in HDR/WDATA, route the granted requester's reqcyc/req/reqtag to m_bus_* combinationally and route m_bus_reqack to sg_reqack only.
REQ-010 SHALL, in RDATA, route m_bus_respcyc/resp/resptag to sg_resp* and sg_respack to m_bus_respack.
REQ-011 SHALL hold the non-granted requester's reqack and respcyc at 0 at all times, its resp/resptag at 0, and never drop a pending non-granted request.
REQ-012 SHALL, on the header handshake (m_bus_reqcyc & m_bus_reqack in HDR), latch the read/write type from tag bit 12 and go to RDATA if 1 or WDATA if 0, clearing the 3-bit beat counter.
REQ-013 SHALL, in WDATA, increment the counter on each m_bus_reqcyc & m_bus_reqack; the 8th beat (counter=7) goes to IDLE.
REQ-014 SHALL, in RDATA, increment the counter on each m_bus_respcyc & m_bus_respack; the 8th beat goes to IDLE.
REQ-015 SHALL update lp to g on every return to IDLE, giving one idle cycle of turnaround between transactions.
REQ-016 SHALL keep the grant through the whole transaction; a beat with ack deasserted stalls with no counter change and no timeout.
REQ-017 SHALL, if the granted requester drops reqcyc in HDR before the ack, stay in HDR and keep the grant.
REQ-018 SHALL ignore m_bus_respcyc outside RDATA, with m_bus_respack=0.

Reset
REQ-019 SHALL, while reset=1 at a posedge, set state=IDLE, g=0, lp=1 (so s0 wins the first tie), and counter=0; this applies even mid-transaction, and all outputs are 0 on the following cycle.

Verification
REQ-020 SHALL verify single read: s1 read, tag 0x1000, addr 0x40 -> m_bus_req=0x40 with tag 0x1000; 8 DRAM beats 0..7 appear on s1_resp in order; s0 sees nothing; IDLE after the 8th ack.
REQ-021 SHALL verify single write: s0 write, tag 0x0005, plus 8 data beats -> header and 8 beats forwarded on m_bus_req; s0_reqack pulses 9 times; then IDLE.
REQ-022 SHALL verify tie and round-robin: from reset both request reads -> s0 served first, s1 second; both again -> s0 first again (lp=1 after s1).
REQ-023 SHALL verify backpressure: in RDATA, hold s1_respack=0 for 5 cycles at beat 3 -> m_bus_respack=0, counter stays 3, and the transaction completes correctly after release.
REQ-024 SHALL verify reset mid-write after beat 4 -> next cycle is IDLE with all outputs 0, and a new s1 request is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// One request/response bus channel between a cache-side requester and the
// memory side.
//   master: drives reqcyc/req/reqtag/respack, receives reqack/respcyc/resp/resptag
//   slave : the mirror image (the arbiter is slave to each cache and master to DRAM)
interface mem_bus_arbiter_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13
);
  logic                      reqcyc;
  logic                      reqack;
  logic [BUS_DATA_WIDTH-1:0] req;
  logic [BUS_TAG_WIDTH-1:0]  reqtag;
  logic                      respcyc;
  logic                      respack;
  logic [BUS_DATA_WIDTH-1:0] resp;
  logic [BUS_TAG_WIDTH-1:0]  resptag;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single DRAM bus.
// A granted requester owns the bus for one whole transaction: a header beat
// (address + tag), then 8 write-data beats or 8 read-response beats.
// Ports:
//   clk    - clock, all state changes on posedge
//   reset  - synchronous active-high reset
//   s0     - instruction cache channel (slave side)
//   s1     - data cache channel (slave side)
//   m_bus  - DRAM channel (master side)
// Routing between the granted requester and DRAM is combinational.
module mem_bus_arbiter #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  s0,
  mem_bus_arbiter_if.slave  s1,
  mem_bus_arbiter_if.master m_bus
);

  localparam int unsigned CNT_W  = 3;
  // Read/write flag is the tag MSB (bit 12 at the default width)
  localparam int unsigned RD_BIT = BUS_TAG_WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(7);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HDR   = 2'd1;
  localparam logic [1:0] WDATA = 2'd2;
  localparam logic [1:0] RDATA = 2'd3;

  logic [1:0]                state_q, state_d;
  logic                      g_q, g_d;
  logic                      lp_q, lp_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic                      sg_reqcyc;
  logic                      sg_respack;
  logic [BUS_DATA_WIDTH-1:0] sg_req;
  logic [BUS_TAG_WIDTH-1:0]  sg_reqtag;

  // Granted requester's outbound signals
  assign sg_reqcyc  = g_q ? s1.reqcyc  : s0.reqcyc;
  assign sg_req     = g_q ? s1.req     : s0.req;
  assign sg_reqtag  = g_q ? s1.reqtag  : s0.reqtag;
  assign sg_respack = g_q ? s1.respack : s0.respack;

  // State register; lp resets to 1 so s0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      lp_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      lp_q    <= lp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and bus routing
  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    lp_d          = lp_q;
    cnt_d         = cnt_q;
    m_bus.reqcyc  = 1'b0;
    m_bus.req     = '0;
    m_bus.reqtag  = '0;
    m_bus.respack = 1'b0;
    s0.reqack     = 1'b0;
    s0.respcyc    = 1'b0;
    s0.resp       = '0;
    s0.resptag    = '0;
    s1.reqack     = 1'b0;
    s1.respcyc    = 1'b0;
    s1.resp       = '0;
    s1.resptag    = '0;

    case (state_q)
      IDLE: begin
        if (s0.reqcyc || s1.reqcyc) begin
          // On a tie, serve whoever was not served last
          g_d     = (s0.reqcyc && s1.reqcyc) ? ~lp_q : s1.reqcyc;
          state_d = HDR;
        end
      end

      HDR, WDATA: begin
        m_bus.reqcyc = sg_reqcyc;
        m_bus.req    = sg_req;
        m_bus.reqtag = sg_reqtag;
        if (g_q) s1.reqack = m_bus.reqack;
        else     s0.reqack = m_bus.reqack;
        if (sg_reqcyc && m_bus.reqack) begin
          if (state_q == HDR) begin
            state_d = sg_reqtag[RD_BIT] ? RDATA : WDATA;
            cnt_d   = '0;
          end else if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            lp_d    = g_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      RDATA: begin
        m_bus.respack = sg_respack;
        if (g_q) begin
          s1.respcyc = m_bus.respcyc;
          s1.resp    = m_bus.resp;
          s1.resptag = m_bus.resptag;
        end else begin
          s0.respcyc = m_bus.respcyc;
          s0.resp    = m_bus.resp;
          s0.resptag = m_bus.resptag;
        end
        if (m_bus.respcyc && sg_respack) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            lp_d    = g_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
